dbus_arbiter: RTL and testbench

Two-master arbiter and sequencer in front of the data bus controller (RAM plus DBC registers). It shares the single data bus between the core load/store unit (master 0) and the debug/DMA port (master 1) using round-robin arbitration. For each granted transaction it waits for bus readiness, issues exactly one rd or wd strobe, captures read data, and returns a one-cycle done/err response. It also filters misaligned or illegal-size requests and times out stalled accesses, so a bad access never reaches the bus.

---
 rtl/dbus_arb_pkg.sv | 38 +++
 rtl/dbus_arbiter_rr_pick2.sv | 15 +
 rtl/dbus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_arb_pkg.sv
// Shared types and helpers for the two-master data bus arbiter.
package dbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STAT_W = 16;

    // Latched command of the granted master.
    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // 1 when the access is misaligned for its size or the size is illegal.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// Two-way round-robin winner select; purely combinational.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       win_o,
    output logic       vld_o
);

    // Sole requester wins; on contention the master not granted last time wins.
    always_comb begin
        vld_o = |req_i;
        win_o = (req_i == 2'b11) ? ~last_gnt_i : req_i[1];
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter and single-access sequencer for the data bus.
// Optional macro DBUS_ARB_STATS_EN adds saturating grant/error counters.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DBUS_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_err,
`endif
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_rd,
    output logic              bus_wd,
    output logic [1:0]        bus_size_in,
    output logic [1:0]        bus_size_out,
    output logic [ADDR_W-1:0] bus_addr_in,
    output logic [ADDR_W-1:0] bus_addr_out,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    input  logic              bus_busy
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    cmd_t              win_cmd;
    logic              mst_q, mst_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              win, win_vld;
    logic              bus_go, to_hit, win_bad;

    rr_pick2 u_pick (
        .req_i      ({m1_req, m0_req}),
        .last_gnt_i (last_q),
        .win_o      (win),
        .vld_o      (win_vld)
    );

    // Command of the current winner and the derived status terms.
    always_comb begin
        win_cmd = win ? cmd_t'{m1_we, m1_size, m1_addr, m1_wdata}
                      : cmd_t'{m0_we, m0_size, m0_addr, m0_wdata};
        win_bad = misaligned(win_cmd.size, win_cmd.addr[1:0]);
        bus_go  = bus_ready && !bus_busy;
        to_hit  = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // State register; reset mid-transaction abandons it silently.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win_vld) state_d = win_bad ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (bus_go || to_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of latched command, timeout counter and response.
    always_comb begin
        cmd_d   = cmd_q;
        mst_d   = mst_q;
        last_d  = last_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    cmd_d   = win_cmd;
                    mst_d   = win;
                    last_d  = win;
                    err_d   = win_bad;
                    rdata_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (bus_go) begin
                    if (!cmd_q.we) rdata_d = bus_rdata;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_RESP: cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q   <= '0;
            mst_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            cmd_q   <= cmd_d;
            mst_q   <= mst_d;
            last_q  <= last_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        m0_done      = 1'b0;
        m1_done      = 1'b0;
        m0_err       = 1'b0;
        m1_err       = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        bus_rd       = 1'b0;
        bus_wd       = 1'b0;
        bus_size_in  = '0;
        bus_size_out = '0;
        bus_addr_in  = '0;
        bus_addr_out = '0;
        bus_wdata    = '0;
        if (rst) begin
            if (state_q == ST_IDLE) begin
                m0_gnt = m0_req && !win;
                m1_gnt = m1_req && win;
            end else begin
                bus_size_in  = cmd_q.size;
                bus_size_out = cmd_q.size;
                bus_addr_in  = cmd_q.addr;
                bus_addr_out = cmd_q.addr;
                bus_wdata    = cmd_q.wdata;
            end
            if (state_q == ST_ISSUE && bus_go) begin
                bus_rd = !cmd_q.we;
                bus_wd = cmd_q.we;
            end
            if (state_q == ST_RESP) begin
                if (mst_q) begin
                    m1_done  = 1'b1;
                    m1_err   = err_q;
                    m1_rdata = rdata_q;
                end else begin
                    m0_done  = 1'b1;
                    m0_err   = err_q;
                    m0_rdata = rdata_q;
                end
            end
        end
    end

`ifdef DBUS_ARB_STATS_EN
    logic [STAT_W-1:0] st_g0_q, st_g1_q, st_err_q;

    // Saturating grant and error-response counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_g0_q  <= '0;
            st_g1_q  <= '0;
            st_err_q <= '0;
        end else begin
            if (m0_gnt && st_g0_q != '1) st_g0_q <= st_g0_q + STAT_W'(1);
            if (m1_gnt && st_g1_q != '1) st_g1_q <= st_g1_q + STAT_W'(1);
            if (state_q == ST_RESP && err_q && st_err_q != '1)
                st_err_q <= st_err_q + STAT_W'(1);
        end
    end

    assign stat_gnt0 = st_g0_q;
    assign stat_gnt1 = st_g1_q;
    assign stat_err  = st_err_q;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_rd, bus_wd, bus_ready, bus_busy;
    logic [1:0]  bus_size_in, bus_size_out;
    logic [31:0] bus_addr_in, bus_addr_out, bus_wdata, bus_rdata;
`ifdef DBUS_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
`ifdef DBUS_ARB_STATS_EN
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_err(stat_err),
`endif
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .bus_rd(bus_rd), .bus_wd(bus_wd),
        .bus_size_in(bus_size_in), .bus_size_out(bus_size_out),
        .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .bus_busy(bus_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int m, input logic req, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_size = sz; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_size = sz; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    // One uncontended transaction on a ready bus, checked cycle by cycle.
    task automatic txn(input int m, input logic we, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
        set_cmd(m, 1'b1, we, sz, addr, wd);
        #1;
        chk("gnt_own", (m == 0) ? m0_gnt : m1_gnt, 1);
        chk("gnt_other", (m == 0) ? m1_gnt : m0_gnt, 0);
        step();
        set_cmd(m, 1'b0, we, sz, addr, wd);
        #1;
        if (!exp_err) begin
            chk("strobe", we ? bus_wd : bus_rd, 1);
            chk("strobe_other", we ? bus_rd : bus_wd, 0);
            chk("bus_addr_in", bus_addr_in, addr);
            chk("bus_addr_out", bus_addr_out, addr);
            chk("bus_size_in", 32'(bus_size_in), 32'(sz));
            if (we) chk("bus_wdata", bus_wdata, wd);
            step();
        end
        chk("no_strobe_resp", 32'({bus_rd, bus_wd}), 0);
        chk("done_own", (m == 0) ? m0_done : m1_done, 1);
        chk("done_other", (m == 0) ? m1_done : m0_done, 0);
        chk("err", (m == 0) ? m0_err : m1_err, 32'(exp_err));
        chk("rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; bus_ready = 1'b1; bus_busy = 1'b0; bus_rdata = '0;
        set_cmd(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_cmd(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) step();

        // Reset: gnt forced low, outputs quiet.
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_done", 32'({m0_done, m1_done}), 0);
        chk("rst_bus_addr", bus_addr_in, 0);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("idle_bus_addr", bus_addr_out, 0);

        // Word write then read-back from the bus model.
        txn(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        bus_rdata = 32'hDEADBEEF;
        txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Misaligned and illegal-size requests never touch the bus.
        txn(1, 1'b0, 2'b01, 32'h3, 32'h0, 1'b1, 32'h0);
        txn(1, 1'b0, 2'b11, 32'h0, 32'h0, 1'b1, 32'h0);
        txn(0, 1'b1, 2'b10, 32'h6, 32'h55, 1'b1, 32'h0);

        // Contention: last grant was m0, so m1, m0, m1, m0.
        set_cmd(0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 2'b10, 32'h80, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_rdata = 32'hA000_0000 + 32'(i);
            #1;
            chk("rr_m1_gnt", m1_gnt, 32'((i % 2) == 0));
            chk("rr_m0_gnt", m0_gnt, 32'((i % 2) == 1));
            step();
            chk("rr_issue_gnt", 32'({m0_gnt, m1_gnt}), 0);
            chk("rr_bus_rd", bus_rd, 1);
            chk("rr_addr", bus_addr_in, ((i % 2) == 0) ? 32'h80 : 32'h40);
            step();
            chk("rr_m1_done", m1_done, 32'((i % 2) == 0));
            chk("rr_m0_done", m0_done, 32'((i % 2) == 1));
            chk("rr_rdata", ((i % 2) == 0) ? m1_rdata : m0_rdata, 32'hA000_0000 + 32'(i));
            chk("rr_other_rdata", ((i % 2) == 0) ? m0_rdata : m1_rdata, 0);
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Timeout: bus never ready, err done 17 cycles after gnt.
        bus_ready = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        #1;
        chk("to_gnt", m0_gnt, 1);
        step();
        m0_req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("to_no_strobe", 32'({bus_rd, bus_wd}), 0);
            chk("to_no_done", m0_done, 0);
            step();
        end
        chk("to_done", m0_done, 1);
        chk("to_err", m0_err, 1);
        chk("to_rdata", m0_rdata, 0);
        step();
        chk("to_idle_addr", bus_addr_in, 0);
        chk("to_idle_done", m0_done, 0);

        // Ready after 5 cycles (last two of them busy): strobe at gnt+6.
        set_cmd(0, 1'b1, 1'b1, 2'b10, 32'h24, 32'h1234);
        #1;
        chk("dly_gnt", m0_gnt, 1);
        step();
        m0_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus_ready = (k >= 4); bus_busy = (k >= 4);
            #1;
            chk("dly_no_strobe", bus_wd, 0);
            step();
        end
        bus_ready = 1'b1; bus_busy = 1'b0;
        #1;
        chk("dly_strobe", bus_wd, 1);
        step();
        chk("dly_done", m0_done, 1);
        chk("dly_err", m0_err, 0);
        step();

        // Reset while in ISSUE: silent abort, then m0 wins contention.
        bus_ready = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
        #1;
        chk("rsti_gnt", m0_gnt, 1);
        step();
        m0_req = 1'b0;
        rst = 1'b0; bus_ready = 1'b1;
        #1;
        chk("rsti_no_rd", bus_rd, 0);
        chk("rsti_addr", bus_addr_in, 0);
        step();
        chk("rsti_no_done", m0_done, 0);
        chk("rsti_no_err", m0_err, 0);
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        chk("rsti_gnt_forced", 32'({m0_gnt, m1_gnt}), 0);
        step();
        rst = 1'b1;
        #1;
        chk("post_rst_m0_gnt", m0_gnt, 1);
        chk("post_rst_m1_gnt", m1_gnt, 0);
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        chk("post_rst_rd", bus_rd, 1);
        step();
        chk("post_rst_done", m0_done, 1);
        chk("post_rst_m1_done", m1_done, 0);
        step();

`ifdef DBUS_ARB_STATS_EN
        // One m0 grant since reset; add two m1, two m0 (one misaligned).
        bus_rdata = 32'h0;
        txn(1, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 32'h0);
        txn(0, 1'b0, 2'b10, 32'h4, 32'h0, 1'b0, 32'h0);
        txn(1, 1'b0, 2'b00, 32'h1, 32'h0, 1'b0, 32'h0);
        txn(0, 1'b0, 2'b10, 32'h2, 32'h0, 1'b1, 32'h0);
        chk("stat_gnt0", 32'(stat_gnt0), 3);
        chk("stat_gnt1", 32'(stat_gnt1), 2);
        chk("stat_err", 32'(stat_err), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
